// File: rtl/jump_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// jump_redirect_ctrl
//
// PC-redirect controller for the MIPS16 core. This block sits between the
// control unit / ALU outputs and the PC mux. It decodes three kinds of
// redirect: register jumps (jr/jalr), absolute jumps (j/jal) and taken
// branches. For each one it issues a registered, one-cycle next-PC select.
// A register jump is held off (stall) until its source register is valid.
// Every redirect is followed by a configurable number of squashed
// wrong-path slots.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   valid_in     decode stage holds a valid instruction
//   aluop        ALU op class (2'b10 = R-type)
//   funct        funct field of the instruction
//   jump_in      j / jal
//   link_in      instruction writes the link register (jal)
//   branch_in    conditional branch
//   zero_in      ALU zero flag for the branch compare
//   rs_ready     rs operand valid for jr/jalr
//   pc_sel       0 = pc+2, 1 = branch target, 2 = jump target, 3 = rs
//   redirect     one-cycle pulse, pc_sel valid
//   flush        squash the fetched instruction
//   stall        hold PC and decode register
//   link_we      one-cycle link register write enable
//   stall_err    sticky: a register-jump stall reached STALL_MAX cycles
//   busy         controller not idle
// -----------------------------------------------------------------------------
module jump_redirect_ctrl #(
    parameter int                 FUNCT_W      = 4,
    parameter logic [FUNCT_W-1:0] JR_FUNCT     = 4'b1000,
    parameter logic [FUNCT_W-1:0] JALR_FUNCT   = 4'b1001,
    parameter int                 FLUSH_CYCLES = 1,
    parameter int                 STALL_MAX    = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    input  logic [1:0]         aluop,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               jump_in,
    input  logic               link_in,
    input  logic               branch_in,
    input  logic               zero_in,
    input  logic               rs_ready,
    output logic [1:0]         pc_sel,
    output logic               redirect,
    output logic               flush,
    output logic               stall,
    output logic               link_we,
    output logic               stall_err,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_RS  = 2'd1,
        S_REDIRECT = 2'd2,
        S_FLUSH    = 2'd3
    } state_t;

    localparam logic [1:0] SEL_PC2 = 2'd0;
    localparam logic [1:0] SEL_BR  = 2'd1;
    localparam logic [1:0] SEL_JMP = 2'd2;
    localparam logic [1:0] SEL_RS  = 2'd3;

    // The REDIRECT cycle is itself the first squashed slot, so the FLUSH
    // state only has to cover the remaining ones.
    localparam logic [3:0] FLUSH_REM = 4'(FLUSH_CYCLES - 1);
    localparam logic [7:0] STALL_LIM = 8'(STALL_MAX);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic       link_q, link_d;
    logic [7:0] stall_cnt_q, stall_cnt_d;
    logic [3:0] flush_cnt_q, flush_cnt_d;
    logic       stall_err_q, stall_err_d;

    logic [1:0] pc_sel_q, pc_sel_d;
    logic       redirect_q, redirect_d;
    logic       flush_q, flush_d;
    logic       stall_q, stall_d;
    logic       link_we_q, link_we_d;
    logic       busy_q, busy_d;

    logic is_reg_s;
    logic is_jalr_s;
    logic is_jmp_s;
    logic is_br_s;

    // Instruction class decode; only the R-type op class can alias jr/jalr.
    always_comb begin
        is_reg_s  = (aluop == 2'b10) && ((funct == JR_FUNCT) || (funct == JALR_FUNCT));
        is_jalr_s = (aluop == 2'b10) && (funct == JALR_FUNCT);
        is_jmp_s  = jump_in;
        is_br_s   = branch_in && zero_in;
    end

    // Next-state logic: target/link capture, stall and flush counting.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        link_d      = link_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        stall_err_d = stall_err_q;
        case (state_q)
            S_IDLE: begin
                stall_cnt_d = 8'd0;
                if (valid_in && is_reg_s) begin
                    sel_d  = SEL_RS;
                    link_d = is_jalr_s;
                    if (rs_ready) begin
                        state_d = S_REDIRECT;
                    end else begin
                        state_d = S_WAIT_RS;
                    end
                end else if (valid_in && is_jmp_s) begin
                    sel_d   = SEL_JMP;
                    link_d  = link_in;
                    state_d = S_REDIRECT;
                end else if (valid_in && is_br_s) begin
                    sel_d   = SEL_BR;
                    link_d  = 1'b0;
                    state_d = S_REDIRECT;
                end else begin
                    sel_d   = SEL_PC2;
                    link_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_WAIT_RS: begin
                // Saturate so a very long stall cannot wrap and look short.
                if (stall_cnt_q != 8'hFF) begin
                    stall_cnt_d = stall_cnt_q + 8'd1;
                end else begin
                    stall_cnt_d = stall_cnt_q;
                end
                if (stall_cnt_d >= STALL_LIM) begin
                    stall_err_d = 1'b1;
                end else begin
                    stall_err_d = stall_err_q;
                end
                if (rs_ready) begin
                    state_d = S_REDIRECT;
                end else begin
                    state_d = S_WAIT_RS;
                end
            end
            S_REDIRECT: begin
                flush_cnt_d = FLUSH_REM;
                if (FLUSH_CYCLES > 1) begin
                    state_d = S_FLUSH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q <= 4'd1) begin
                    flush_cnt_d = 4'd0;
                    state_d     = S_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                    state_d     = S_FLUSH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state, so every output is a plain flop.
    always_comb begin
        redirect_d = (state_d == S_REDIRECT);
        flush_d    = (state_d == S_REDIRECT) || (state_d == S_FLUSH);
        stall_d    = (state_d == S_WAIT_RS);
        busy_d     = (state_d != S_IDLE);
        link_we_d  = (state_d == S_REDIRECT) && link_d;
        if (state_d == S_REDIRECT) begin
            pc_sel_d = sel_d;
        end else begin
            pc_sel_d = SEL_PC2;
        end
    end

    // State, bookkeeping and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sel_q       <= 2'd0;
            link_q      <= 1'b0;
            stall_cnt_q <= 8'd0;
            flush_cnt_q <= 4'd0;
            stall_err_q <= 1'b0;
            pc_sel_q    <= 2'd0;
            redirect_q  <= 1'b0;
            flush_q     <= 1'b0;
            stall_q     <= 1'b0;
            link_we_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            link_q      <= link_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            stall_err_q <= stall_err_d;
            pc_sel_q    <= pc_sel_d;
            redirect_q  <= redirect_d;
            flush_q     <= flush_d;
            stall_q     <= stall_d;
            link_we_q   <= link_we_d;
            busy_q      <= busy_d;
        end
    end

    assign pc_sel    = pc_sel_q;
    assign redirect  = redirect_q;
    assign flush     = flush_q;
    assign stall     = stall_q;
    assign link_we   = link_we_q;
    assign stall_err = stall_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for jump_redirect_ctrl. Two instances share one set of inputs:
// u_d1 uses FLUSH_CYCLES=1 and u_d3 uses FLUSH_CYCLES=3. Both use
// STALL_MAX=7. Each instance is compared every cycle against a
// slot-counting reference model. The bench also runs a vector table,
// hand-written corner sequences and a randomized run.
// -----------------------------------------------------------------------------
module tb_jump_redirect_ctrl;

    localparam int STALL_MAX = 7;

    logic       clk;
    logic       rst;
    logic       valid_in;
    logic [1:0] aluop;
    logic [3:0] funct;
    logic       jump_in, link_in, branch_in, zero_in, rs_ready;

    logic [1:0] pc_sel1, pc_sel3;
    logic       redirect1, flush1, stall1, link_we1, stall_err1, busy1;
    logic       redirect3, flush3, stall3, link_we3, stall_err3, busy3;

    jump_redirect_ctrl #(.FLUSH_CYCLES(1), .STALL_MAX(STALL_MAX)) u_d1 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .aluop(aluop), .funct(funct),
        .jump_in(jump_in), .link_in(link_in), .branch_in(branch_in), .zero_in(zero_in),
        .rs_ready(rs_ready), .pc_sel(pc_sel1), .redirect(redirect1), .flush(flush1),
        .stall(stall1), .link_we(link_we1), .stall_err(stall_err1), .busy(busy1)
    );

    jump_redirect_ctrl #(.FLUSH_CYCLES(3), .STALL_MAX(STALL_MAX)) u_d3 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .aluop(aluop), .funct(funct),
        .jump_in(jump_in), .link_in(link_in), .branch_in(branch_in), .zero_in(zero_in),
        .rs_ready(rs_ready), .pc_sel(pc_sel3), .redirect(redirect3), .flush(flush3),
        .stall(stall3), .link_we(link_we3), .stall_err(stall_err3), .busy(busy3)
    );

    // Packed view {pc_sel[7:6], redirect, flush, stall, link_we, stall_err, busy}
    logic [7:0] act1, act3;
    assign act1 = {pc_sel1, redirect1, flush1, stall1, link_we1, stall_err1, busy1};
    assign act3 = {pc_sel3, redirect3, flush3, stall3, link_we3, stall_err3, busy3};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each instance tracks only the following:
    //   - whether it waits for rs and how many stall cycles it has seen,
    //   - how many post-redirect slots remain before a new instruction may
    //     be accepted.
    int         fc[2] = '{1, 3};
    int         m_rem[2];
    bit         m_wait[2];
    int         m_scnt[2];
    bit         m_link[2];
    bit         m_err[2];
    logic [1:0] e_sel[2];
    bit         e_red[2], e_fl[2], e_st[2], e_lk[2], e_busy[2];

    function automatic logic [7:0] exp_pack(input int i);
        return {e_sel[i], e_red[i], e_fl[i], e_st[i], e_lk[i], m_err[i], e_busy[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_rem[i] = 0; m_wait[i] = 0; m_scnt[i] = 0; m_link[i] = 0; m_err[i] = 0;
            e_sel[i] = 2'd0; e_red[i] = 0; e_fl[i] = 0; e_st[i] = 0; e_lk[i] = 0; e_busy[i] = 0;
        end
    endtask

    task automatic model_issue(input int i, input logic [1:0] sel, input bit lk);
        m_wait[i] = 0;
        e_sel[i]  = sel;
        e_red[i]  = 1; e_fl[i] = 1; e_busy[i] = 1; e_lk[i] = lk;
        m_rem[i]  = fc[i];   // redirect slot plus following flush slots
    endtask

    task automatic model_edge(input int i);
        e_sel[i] = 2'd0; e_red[i] = 0; e_fl[i] = 0; e_st[i] = 0; e_lk[i] = 0; e_busy[i] = 0;
        if (m_wait[i]) begin
            m_scnt[i]++;
            if (m_scnt[i] >= STALL_MAX) m_err[i] = 1;
            if (rs_ready) model_issue(i, 2'd3, m_link[i]);
            else begin e_st[i] = 1; e_busy[i] = 1; end
        end else if (m_rem[i] > 0) begin
            m_rem[i]--;
            if (m_rem[i] > 0) begin e_fl[i] = 1; e_busy[i] = 1; end
        end else if (valid_in) begin
            if (aluop == 2'b10 && (funct == 4'b1000 || funct == 4'b1001)) begin
                if (rs_ready) model_issue(i, 2'd3, funct == 4'b1001);
                else begin
                    m_wait[i] = 1; m_scnt[i] = 0; m_link[i] = (funct == 4'b1001);
                    e_st[i] = 1; e_busy[i] = 1;
                end
            end else if (jump_in) model_issue(i, 2'd2, link_in);
            else if (branch_in && zero_in) model_issue(i, 2'd1, 1'b0);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input logic v, input logic [1:0] op, input logic [3:0] fn,
                          input logic j, input logic l, input logic b, input logic z,
                          input logic rs);
        valid_in = v; aluop = op; funct = fn;
        jump_in = j; link_in = l; branch_in = b; zero_in = z; rs_ready = rs;
    endtask

    task automatic idle_in();
        set_in(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // One clock: model sees the same inputs as the DUT at the edge, then compare.
    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        chk("model_fc1", act1, exp_pack(0));
        chk("model_fc3", act3, exp_pack(1));
    endtask

    // Mid-cycle asynchronous reset: outputs must clear before any clock edge.
    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("reset_fc1", act1, 8'h00);
        chk("reset_fc3", act3, 8'h00);
        #1;
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic       v;
        logic [1:0] op;
        logic [3:0] fn;
        logic       j, l, b, z, rs;
        logic [7:0] exp1;
    } vec_t;

    vec_t vecs[14];

    initial begin
        rst = 1'b0;
        idle_in();
        model_reset();
        #1;
        pulse_reset();

        // ---------- table-driven vectors (expected values for FLUSH_CYCLES=1) ----------
        //            v     op     fn       j     l     b     z     rs    {sel,red,fl,st,lk,err,busy}
        vecs[0]  = '{1'b1, 2'b10, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'b11110001}; // jr ready
        vecs[1]  = '{1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'b00000000}; // back to idle
        vecs[2]  = '{1'b1, 2'b00, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'b00000000}; // non-R alias
        vecs[3]  = '{1'b1, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'b00000000}; // branch not taken
        vecs[4]  = '{1'b1, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'b01110001}; // branch taken
        vecs[5]  = '{1'b1, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'b00000000}; // ignored while busy
        vecs[6]  = '{1'b1, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'b10110101}; // jal beats branch
        vecs[7]  = '{1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'b00000000};
        vecs[8]  = '{1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'b00000000}; // valid_in low
        vecs[9]  = '{1'b1, 2'b10, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'b11110101}; // jalr beats j
        vecs[10] = '{1'b1, 2'b10, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'b00000000};
        vecs[11] = '{1'b1, 2'b10, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'b00000000}; // other funct
        vecs[12] = '{1'b1, 2'b11, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'b00000000}; // aluop 11
        vecs[13] = '{1'b1, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'b10110001}; // plain j
        for (int k = 0; k < 14; k++) begin
            set_in(vecs[k].v, vecs[k].op, vecs[k].fn, vecs[k].j, vecs[k].l,
                   vecs[k].b, vecs[k].z, vecs[k].rs);
            step();
            chk($sformatf("vec%0d", k), act1, vecs[k].exp1);
        end
        idle_in();
        step();
        pulse_reset();

        // ---------- jalr with a 3-cycle rs hazard ----------
        set_in(1'b1, 2'b10, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("jalr_stall1", act1, 8'b00001001);
        set_in(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("jalr_stall2", act1, 8'b00001001);
        step();
        chk("jalr_stall3", act1, 8'b00001001);
        rs_ready = 1'b1;
        step();
        chk("jalr_redirect", act1, 8'b11110101);
        idle_in();
        step();
        chk("jalr_idle", act1, 8'b00000000);
        pulse_reset();

        // ---------- priority and flush depth (FLUSH_CYCLES=3) ----------
        set_in(1'b1, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step();
        chk("prio_sel_jump", act3, 8'b10110001);
        set_in(1'b1, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);  // valid pulse during flush
        step();
        chk("flush_slot2", act3, 8'b00010001);
        idle_in();
        step();
        chk("flush_slot3", act3, 8'b00010001);
        step();
        chk("flush_done", act3, 8'b00000000);
        pulse_reset();

        // ---------- reset during the second flush cycle ----------
        set_in(1'b1, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        idle_in();
        step();
        chk("rstflush_slot2", act3, 8'b00010001);
        pulse_reset();
        set_in(1'b1, 2'b10, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk("after_rst_jr", act3, 8'b11110001);
        idle_in();
        step();
        pulse_reset();

        // ---------- stall timeout: rs_ready low for 10 edges ----------
        set_in(1'b1, 2'b10, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        set_in(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) step();
        chk("timeout_7cyc_noerr", act1, 8'b00001001);
        step();
        chk("timeout_err_rise", act1, 8'b00001011);
        step();
        step();
        rs_ready = 1'b1;
        step();
        chk("timeout_redirect", act1, 8'b11110011);
        idle_in();
        step();
        step();
        chk("timeout_err_sticky", act1, 8'b00000010);
        chk("timeout_err_sticky3", act3, 8'b00010011);
        pulse_reset();

        // ---------- randomized run against the model ----------
        for (int k = 0; k < 3000; k++) begin
            int thr;
            thr = ((k / 400) % 2 == 0) ? 8 : 2;
            valid_in  = ($urandom_range(0, 3) != 0);
            aluop     = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       funct = 4'b1000;
                1:       funct = 4'b1001;
                default: funct = 4'($urandom_range(0, 15));
            endcase
            jump_in   = ($urandom_range(0, 3) == 0);
            link_in   = $urandom_range(0, 1) == 1;
            branch_in = ($urandom_range(0, 2) == 0);
            zero_in   = $urandom_range(0, 1) == 1;
            rs_ready  = ($urandom_range(0, 9) < thr);
            step();
            if ($urandom_range(0, 299) == 0) pulse_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/jump_redirect_ctrl.md
Name: jump_redirect_ctrl

Overview:
Parametrised PC-redirect controller for the MIPS16 core. It decodes register jumps (jr/jalr), absolute jumps (j/jal) and taken branches, and issues a one-cycle registered next-PC select. It stalls register jumps until the source register is ready, then flushes a configurable number of wrong-path slots. It sits between the control unit/ALU outputs and the PC mux, replacing the single-bit jr select.

Parameters:
FUNCT_W, 4, width of the funct field
JR_FUNCT, 4'b1000, funct code for jr (valid when aluop==2'b10)
JALR_FUNCT, 4'b1001, funct code for jalr (valid when aluop==2'b10)
FLUSH_CYCLES, 1, wrong-path slots squashed after a redirect (1..15)
STALL_MAX, 7, maximum consecutive rs-not-ready cycles before the error flag is raised (1..255)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
valid_in  input  1  decode stage holds a valid instruction this cycle
aluop  input  2  ALU op class from the control unit; 2'b10 = R-type
funct  input  FUNCT_W  funct field from the instruction line
jump_in  input  1  control unit: j or jal
link_in  input  1  control unit: instruction writes the link register (jal)
branch_in  input  1  control unit: conditional branch
zero_in  input  1  ALU zero flag for the branch compare
rs_ready  input  1  forwarding/hazard unit: rs value valid for jr/jalr
pc_sel  output  2  0 = pc+2, 1 = branch target, 2 = jump target, 3 = rs register
redirect  output  1  one-cycle pulse; pc_sel is valid this cycle
flush  output  1  squash the fetched instruction this cycle
stall  output  1  hold the PC and decode register
link_we  output  1  one-cycle write enable for the link register (jal/jalr)
stall_err  output  1  sticky flag; stall exceeded STALL_MAX
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (async, rst=1): state IDLE. pc_sel=0, redirect=0, flush=0, stall=0, link_we=0, stall_err=0, busy=0, counters=0. Reset takes effect immediately, including mid-stall or mid-flush.
- Decode (combinational, only when valid_in=1 in IDLE):
  - is_reg = (aluop==2'b10) && (funct==JR_FUNCT || funct==JALR_FUNCT)
  - is_jmp = jump_in
  - is_br = branch_in && zero_in
  - Priority: is_reg > is_jmp > is_br. aluop other than 2'b10 never qualifies as a register jump.
- FSM states: IDLE, WAIT_RS, REDIRECT, FLUSH.
- IDLE:
  - is_reg && !rs_ready -> WAIT_RS; stall=1 from the next cycle.
  - is_reg && rs_ready -> REDIRECT with pc_sel=3.
  - is_jmp -> REDIRECT with pc_sel=2.
  - is_br -> REDIRECT with pc_sel=1.
  - Otherwise remain in IDLE with pc_sel=0.
- WAIT_RS:
  - stall=1 and the stall counter increments every cycle.
  - When rs_ready=1 -> REDIRECT with pc_sel=3; stall deasserts on entering REDIRECT.
  - If the counter reaches STALL_MAX, set stall_err=1 (sticky until rst) and keep waiting.
- REDIRECT:
  - Lasts exactly one cycle: redirect=1, pc_sel held, flush=1.
  - link_we=1 if the instruction was jalr, or jal (link_in=1).
  - Then -> FLUSH if FLUSH_CYCLES>1, else -> IDLE.
- FLUSH:
  - flush=1 for the remaining FLUSH_CYCLES-1 cycles; valid_in is ignored.
  - Then -> IDLE.
- All outputs are registered; decision-to-redirect latency is 1 cycle from the decode clock edge.
- Outside REDIRECT: redirect=0, link_we=0, pc_sel=0.
- busy=1 in every state except IDLE.
- A new instruction is never accepted while busy. Back-to-back jumps are separated by at least 1+FLUSH_CYCLES cycles.
- rs_ready changing in the same cycle the FSM enters WAIT_RS is sampled on the next edge, so there is no zero-length stall.

Test Plan:
- Reset mid-FLUSH (FLUSH_CYCLES=3): assert rst during the second flush cycle -> all outputs 0 immediately; state IDLE; next jr accepted normally.
- jr with rs ready: aluop=2'b10, funct=4'b1000, rs_ready=1, valid_in=1 -> next cycle pc_sel=3, redirect=1, flush=1, link_we=0; then IDLE, pc_sel=0.
- jalr with 3-cycle hazard: funct=4'b1001, rs_ready=0 for 3 cycles -> stall=1 for 3 cycles; then pc_sel=3, redirect=1, link_we=1; stall_err stays 0.
- Priority and flush depth: FLUSH_CYCLES=3, jump_in=1 and branch_in=1 with zero_in=1 together -> pc_sel=2 (not 1); flush=1 for 3 consecutive cycles; a valid_in pulse during flush produces no redirect.
- Non-R-type funct alias: aluop=2'b00, funct=4'b1000 -> no redirect, pc_sel=0; branch_in=1 with zero_in=0 -> no redirect.
- Stall timeout: STALL_MAX=7, rs_ready held 0 for 10 cycles -> stall_err rises after 7 stall cycles and remains 1 after rs_ready=1 and the redirect completes.
